// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared frontend definitions for the fetch PC sequencer: FSM encoding,
// reset PC and fetch-group geometry plus the PC alignment helpers.
package fetch_pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [63:0] FETCH_RESET_PC    = 64'h8000_0000;
    localparam int          FETCH_GROUP_BYTES = 16;

    // Instructions are 4-byte aligned; low two bits of any target are dropped.
    function automatic logic [63:0] align_instr(input logic [63:0] a);
        return {a[63:2], 2'b00};
    endfunction

    function automatic logic [63:0] next_group(input logic [63:0] a);
        logic [63:0] w_mask;
        w_mask = ~(64'(FETCH_GROUP_BYTES) - 64'd1);
        return (a & w_mask) + 64'(FETCH_GROUP_BYTES);
    endfunction

endpackage

// File: rtl/fetch_pc_ctrl_pc_next_calc.sv
// Next fetch PC selection: redirect > predicted-taken > sequential group > hold.
// Prediction path compiled in only with FETCH_PC_CTRL_PREDICT_EN.
module pc_next_calc
    import fetch_pc_ctrl_pkg::*;
(
    input  logic [63:0] i_cur_pc,
    input  logic        i_redirect_valid,
    input  logic [63:0] i_redirect_target,
    input  logic        i_advance,
    input  logic        i_pred_taken,
    input  logic [31:0] i_pred_target,
    output logic [63:0] o_next_pc,
    output logic        o_pred_hit
);

    logic        w_pred_hit;
    logic [63:0] w_pred_pc;

`ifdef FETCH_PC_CTRL_PREDICT_EN
    assign w_pred_hit = i_advance & i_pred_taken;
    assign w_pred_pc  = align_instr({32'd0, i_pred_target});
`else
    logic w_unused_pred;
    assign w_unused_pred = ^{i_pred_taken, i_pred_target};
    assign w_pred_hit    = 1'b0;
    assign w_pred_pc     = '0;
`endif

    always_comb begin
        o_next_pc = i_cur_pc;
        if (i_redirect_valid)
            o_next_pc = align_instr(i_redirect_target);
        else if (w_pred_hit)
            o_next_pc = w_pred_pc;
        else if (i_advance)
            o_next_pc = next_group(i_cur_pc);
    end

    assign o_pred_hit = w_pred_hit;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch sequencer: owns the fetch PC, runs the icache handshake, drops stale
// responses after redirects. Optional prediction: FETCH_PC_CTRL_PREDICT_EN.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    output logic        pc2ic_req_valid,
    output logic [63:0] pc2ic_req_addr,
    input  logic        ic2pc_req_ready,
    input  logic        ic2pc_resp_valid,
    output logic        pc2ic_resp_ready,
    input  logic        ib2pc_ready,
    output logic [63:0] pc,
    output logic        pc_operation_done,
    input  logic        admin2pcctrl_predicttaken,
    input  logic [31:0] admin2pcctrl_predicttarget,
    output logic [63:0] fetch_cnt,
    output logic [63:0] pred_redirect_cnt
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [63:0]  r_pc;
    logic [63:0]  w_next_pc;
    logic [63:0]  r_fetch_cnt;
    logic         w_req_valid;
    logic         w_resp_ready;
    logic         w_done;
    logic         w_pred_hit;

    always_comb begin
        w_state_nxt  = r_state;
        w_req_valid  = 1'b0;
        w_resp_ready = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_REQ;
            ST_REQ: begin
                w_req_valid = 1'b1;
                // A request accepted alongside a redirect carries the old PC.
                if (ic2pc_req_ready)
                    w_state_nxt = redirect_valid ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                w_done       = ic2pc_resp_valid & ib2pc_ready & ~redirect_valid;
                // Under redirect the response is swallowed regardless of ib space.
                w_resp_ready = w_done | (ic2pc_resp_valid & redirect_valid);
                if (w_resp_ready)
                    w_state_nxt = ST_REQ;
                else if (redirect_valid)
                    w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_resp_ready = ic2pc_resp_valid;
                if (ic2pc_resp_valid)
                    w_state_nxt = ST_REQ;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    pc_next_calc u_pc_next_calc (
        .i_cur_pc          (r_pc),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .i_advance         (w_done),
        .i_pred_taken      (admin2pcctrl_predicttaken),
        .i_pred_target     (admin2pcctrl_predicttarget),
        .o_next_pc         (w_next_pc),
        .o_pred_hit        (w_pred_hit)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            r_fetch_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_next_pc;
            if (w_done)
                r_fetch_cnt <= r_fetch_cnt + 64'd1;
        end
    end

`ifdef FETCH_PC_CTRL_PREDICT_EN
    logic [63:0] r_pred_cnt;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_pred_cnt <= '0;
        else if (w_pred_hit)
            r_pred_cnt <= r_pred_cnt + 64'd1;
    end
    assign pred_redirect_cnt = r_pred_cnt;
`else
    logic w_unused_hit;
    assign w_unused_hit      = w_pred_hit;
    assign pred_redirect_cnt = '0;
`endif

    assign pc2ic_req_valid   = w_req_valid;
    assign pc2ic_req_addr    = r_pc;
    assign pc2ic_resp_ready  = w_resp_ready;
    assign pc_operation_done = w_done;
    assign pc                = r_pc;
    assign fetch_cnt         = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: icache model plus a transaction-level
// reference of the fetch PC stream, directed scenarios and a random soak.
module tb_fetch_pc_ctrl;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        pc2ic_req_valid;
    logic [63:0] pc2ic_req_addr;
    logic        ic2pc_req_ready;
    logic        ic2pc_resp_valid;
    logic        pc2ic_resp_ready;
    logic        ib2pc_ready;
    logic [63:0] pc;
    logic        pc_operation_done;
    logic        admin2pcctrl_predicttaken;
    logic [31:0] admin2pcctrl_predicttarget;
    logic [63:0] fetch_cnt;
    logic [63:0] pred_redirect_cnt;

    fetch_pc_ctrl dut (
        .clock                      (clock),
        .reset_n                    (reset_n),
        .redirect_valid             (redirect_valid),
        .redirect_target            (redirect_target),
        .pc2ic_req_valid            (pc2ic_req_valid),
        .pc2ic_req_addr             (pc2ic_req_addr),
        .ic2pc_req_ready            (ic2pc_req_ready),
        .ic2pc_resp_valid           (ic2pc_resp_valid),
        .pc2ic_resp_ready           (pc2ic_resp_ready),
        .ib2pc_ready                (ib2pc_ready),
        .pc                         (pc),
        .pc_operation_done          (pc_operation_done),
        .admin2pcctrl_predicttaken  (admin2pcctrl_predicttaken),
        .admin2pcctrl_predicttarget (admin2pcctrl_predicttarget),
        .fetch_cnt                  (fetch_cnt),
        .pred_redirect_cnt          (pred_redirect_cnt)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: PC the next request must carry, delivery counters, and
    // the single outstanding icache transaction (alive or doomed by a redirect).
    logic [63:0] m_pc, m_fetch, m_pred;
    bit          m_out, m_live, m_idle;
    int          m_lat, lat_cfg;
    logic [63:0] acc_q[$];
    logic [258:0] o_vec, e_vec;

    task automatic model_reset();
        m_pc = RST_PC; m_fetch = '0; m_pred = '0;
        m_out = 0; m_live = 0; m_idle = 1; m_lat = 0;
        acc_q.delete();
    endtask

    task automatic drive_idle();
        redirect_valid = 0; redirect_target = '0; ic2pc_req_ready = 0;
        ic2pc_resp_valid = 0; ib2pc_ready = 0;
        admin2pcctrl_predicttaken = 0; admin2pcctrl_predicttarget = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 0;
        drive_idle();
        model_reset();
        @(posedge clock);
        #2 reset_n = 1;
    endtask

    // One clock of stimulus; leaves observed/expected vectors for the caller.
    task automatic step(input bit ibr, input bit rqr, input bit rd, input logic [63:0] rt,
                        input bit tk, input logic [31:0] tt);
        bit e_reqv, e_rr, e_done, req_hs, resp_hs;
        @(negedge clock);
        ib2pc_ready = ibr; ic2pc_req_ready = rqr; redirect_valid = rd; redirect_target = rt;
        admin2pcctrl_predicttaken = tk; admin2pcctrl_predicttarget = tt;
        ic2pc_resp_valid = m_out && (m_lat == 0);
        #1;
        e_reqv = !m_out && !m_idle;
        e_done = ic2pc_resp_valid && m_live && ibr && !rd;
        e_rr   = ic2pc_resp_valid && (!m_live || rd || ibr);
        e_vec = {e_reqv, e_rr, e_done, (e_reqv ? m_pc : 64'd0), m_pc, m_fetch, m_pred};
        o_vec = {pc2ic_req_valid, pc2ic_resp_ready, pc_operation_done,
                 (pc2ic_req_valid ? pc2ic_req_addr : 64'd0), pc, fetch_cnt, pred_redirect_cnt};
        req_hs  = (pc2ic_req_valid === 1'b1) && rqr;
        resp_hs = ic2pc_resp_valid && (pc2ic_resp_ready === 1'b1);
        if (req_hs) acc_q.push_back(pc2ic_req_addr);
        m_idle = 0;
        if (e_done) m_fetch = m_fetch + 1;
`ifdef FETCH_PC_CTRL_PREDICT_EN
        if (e_done && tk) m_pred = m_pred + 1;
        if (rd) m_pc = rt & ~64'd3;
        else if (e_done && tk) m_pc = {32'd0, tt} & ~64'd3;
        else if (e_done) m_pc = (m_pc & ~64'hF) + 64'd16;
`else
        if (rd) m_pc = rt & ~64'd3;
        else if (e_done) m_pc = (m_pc & ~64'hF) + 64'd16;
`endif
        if (resp_hs) m_out = 0;
        else if (m_out) begin
            if (rd) m_live = 0;
            if (m_lat > 0) m_lat--;
        end
        if (req_hs) begin m_out = 1; m_live = !rd; m_lat = lat_cfg; end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset_n = 0;
        drive_idle();
        ic2pc_resp_valid = 1; ib2pc_ready = 1; ic2pc_req_ready = 1;
        model_reset();
        #1;
        n_cmp++; if (pc2ic_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid got %b want 0", pc2ic_req_valid); end
        n_cmp++; if (pc2ic_resp_ready !== 1'b0) begin n_err++; $display("FAIL rst_resp_ready got %b want 0", pc2ic_resp_ready); end
        n_cmp++; if (pc_operation_done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", pc_operation_done); end
        n_cmp++; if (pc !== RST_PC) begin n_err++; $display("FAIL rst_pc got %h want %h", pc, RST_PC); end
        n_cmp++; if (fetch_cnt !== 64'd0) begin n_err++; $display("FAIL rst_fetch_cnt got %h want 0", fetch_cnt); end
        n_cmp++; if (pred_redirect_cnt !== 64'd0) begin n_err++; $display("FAIL rst_pred_cnt got %h want 0", pred_redirect_cnt); end
        drive_idle();
        @(posedge clock);
        #2 reset_n = 1;
        lat_cfg = 1;
        for (int c = 0; c < 2; c++) begin
            step(1, 1, 0, 0, 0, 0);
            n_cmp++; if (o_vec !== e_vec) begin n_err++; $display("FAIL rst_first_req cyc%0d got %h want %h", c, o_vec, e_vec); end
        end
    endtask

    task automatic test_sequential();
        int c = 0;
        do_reset();
        lat_cfg = 1;
        while (m_fetch < 3 && c < 40) begin
            step(1, 1, 0, 0, 0, 0);
            n_cmp++; if (o_vec !== e_vec) begin n_err++; $display("FAIL seq cyc%0d got %h want %h", c, o_vec, e_vec); end
            c++;
        end
        step(1, 0, 0, 0, 0, 0);
        n_cmp++; if (acc_q.size() < 3) begin n_err++; $display("FAIL seq_reqs got %0d want 3", acc_q.size()); end
        else begin
            n_cmp++; if (acc_q[0] !== 64'h8000_0000) begin n_err++; $display("FAIL seq_addr0 got %h want 80000000", acc_q[0]); end
            n_cmp++; if (acc_q[1] !== 64'h8000_0010) begin n_err++; $display("FAIL seq_addr1 got %h want 80000010", acc_q[1]); end
            n_cmp++; if (acc_q[2] !== 64'h8000_0020) begin n_err++; $display("FAIL seq_addr2 got %h want 80000020", acc_q[2]); end
        end
        n_cmp++; if (fetch_cnt !== 64'd3) begin n_err++; $display("FAIL seq_fetch_cnt got %0d want 3", fetch_cnt); end
    endtask

    task automatic test_align();
        int c = 0;
        do_reset();
        lat_cfg = 1;
        step(1, 1, 1, 64'h8000_0009, 0, 0);
        while (acc_q.size() < 2 && c < 40) begin
            step(1, 1, 0, 0, 0, 0);
            n_cmp++; if (o_vec !== e_vec) begin n_err++; $display("FAIL align cyc%0d got %h want %h", c, o_vec, e_vec); end
            c++;
        end
        n_cmp++; if (acc_q.size() < 2) begin n_err++; $display("FAIL align_timeout got %0d reqs want 2", acc_q.size()); end
        else begin
            n_cmp++; if (acc_q[0] !== 64'h8000_0008) begin n_err++; $display("FAIL align_first got %h want 80000008", acc_q[0]); end
            n_cmp++; if (acc_q[1] !== 64'h8000_0010) begin n_err++; $display("FAIL align_next got %h want 80000010", acc_q[1]); end
        end
    endtask

    task automatic test_predict();
        int c = 0;
        logic [63:0] exp_addr, exp_cnt;
`ifdef FETCH_PC_CTRL_PREDICT_EN
        exp_addr = 64'h8000_1234; exp_cnt = 64'd1;
`else
        exp_addr = 64'h8000_0010; exp_cnt = 64'd0;
`endif
        do_reset();
        lat_cfg = 1;
        while (acc_q.size() < 2 && c < 40) begin
            step(1, 1, 0, 0, 1, 32'h8000_1236);
            n_cmp++; if (o_vec !== e_vec) begin n_err++; $display("FAIL pred cyc%0d got %h want %h", c, o_vec, e_vec); end
            c++;
        end
        n_cmp++; if (acc_q.size() < 2) begin n_err++; $display("FAIL pred_timeout got %0d reqs want 2", acc_q.size()); end
        else begin
            n_cmp++; if (acc_q[1] !== exp_addr) begin n_err++; $display("FAIL pred_addr got %h want %h", acc_q[1], exp_addr); end
        end
        n_cmp++; if (pred_redirect_cnt !== exp_cnt) begin n_err++; $display("FAIL pred_cnt got %0d want %0d", pred_redirect_cnt, exp_cnt); end
    endtask

    task automatic test_backpressure();
        int c = 0;
        do_reset();
        lat_cfg = 0;
        while (!(m_out && m_lat == 0) && c < 20) begin step(0, 1, 0, 0, 0, 0); c++; end
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 0, 0, 0);
            n_cmp++; if (o_vec !== e_vec) begin n_err++; $display("FAIL bp_hold cyc%0d got %h want %h", k, o_vec, e_vec); end
            n_cmp++; if (pc_operation_done !== 1'b0 || pc2ic_resp_ready !== 1'b0)
                begin n_err++; $display("FAIL bp_nodone cyc%0d got done=%b rr=%b want 0/0", k, pc_operation_done, pc2ic_resp_ready); end
        end
        step(1, 1, 0, 0, 0, 0);
        n_cmp++; if (pc_operation_done !== 1'b1 || pc2ic_resp_ready !== 1'b1)
            begin n_err++; $display("FAIL bp_release got done=%b rr=%b want 1/1", pc_operation_done, pc2ic_resp_ready); end
    endtask

    task automatic test_redirect_wait();
        int c = 0;
        do_reset();
        lat_cfg = 2;
        while (!(m_out && m_lat == 1) && c < 20) begin step(1, 1, 0, 0, 0, 0); c++; end
        step(1, 1, 1, 64'h8000_2000, 0, 0);
        c = 0;
        while (acc_q.size() < 2 && c < 40) begin
            step(1, 1, 0, 0, 0, 0);
            n_cmp++; if (o_vec !== e_vec) begin n_err++; $display("FAIL rdw cyc%0d got %h want %h", c, o_vec, e_vec); end
            c++;
        end
        n_cmp++; if (acc_q.size() < 2) begin n_err++; $display("FAIL rdw_timeout got %0d reqs want 2", acc_q.size()); end
        else begin
            n_cmp++; if (acc_q[1] !== 64'h8000_2000) begin n_err++; $display("FAIL rdw_addr got %h want 80002000", acc_q[1]); end
        end
        n_cmp++; if (fetch_cnt !== 64'd0) begin n_err++; $display("FAIL rdw_fetch_cnt got %0d want 0", fetch_cnt); end
    endtask

    task automatic test_redirect_same();
        int c = 0;
        do_reset();
        lat_cfg = 1;
        while (!(m_out && m_lat == 0) && c < 20) begin step(1, 1, 0, 0, 0, 0); c++; end
        step(1, 1, 1, 64'h8000_3000, 0, 0);
        n_cmp++; if (pc_operation_done !== 1'b0 || pc2ic_resp_ready !== 1'b1)
            begin n_err++; $display("FAIL rds_cycle got done=%b rr=%b want 0/1", pc_operation_done, pc2ic_resp_ready); end
        c = 0;
        while (acc_q.size() < 2 && c < 40) begin
            step(1, 1, 0, 0, 0, 0);
            n_cmp++; if (o_vec !== e_vec) begin n_err++; $display("FAIL rds cyc%0d got %h want %h", c, o_vec, e_vec); end
            c++;
        end
        n_cmp++; if (acc_q.size() < 2 || acc_q[acc_q.size()-1] !== 64'h8000_3000)
            begin n_err++; $display("FAIL rds_addr got %0d reqs last %h want 80003000", acc_q.size(), (acc_q.size() > 0) ? acc_q[acc_q.size()-1] : 64'd0); end
    endtask

    task automatic test_reset_drain();
        int c = 0;
        do_reset();
        lat_cfg = 3;
        while (!m_out && c < 20) begin step(1, 1, 0, 0, 0, 0); c++; end
        step(1, 1, 1, 64'h8000_4000, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        n_cmp++; if (o_vec !== e_vec) begin n_err++; $display("FAIL rstd_drain got %h want %h", o_vec, e_vec); end
        #3 reset_n = 0;
        drive_idle();
        model_reset();
        #1;
        n_cmp++; if (pc !== RST_PC || pc2ic_req_valid !== 1'b0 || pc2ic_resp_ready !== 1'b0)
            begin n_err++; $display("FAIL rstd_async got pc=%h rv=%b rr=%b want %h/0/0", pc, pc2ic_req_valid, pc2ic_resp_ready, RST_PC); end
        @(posedge clock);
        #2 reset_n = 1;
        lat_cfg = 1;
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0, 0, 0, 0);
            n_cmp++; if (o_vec !== e_vec) begin n_err++; $display("FAIL rstd_restart cyc%0d got %h want %h", k, o_vec, e_vec); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            lat_cfg = $urandom_range(0, 3);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                 {$urandom, $urandom}, $urandom_range(0, 3) == 0, $urandom);
            n_cmp++; if (o_vec !== e_vec) begin n_err++; $display("FAIL rand cyc%0d got %h want %h", c, o_vec, e_vec); end
        end
    endtask

    initial begin
        reset_n = 1;
        drive_idle();
        lat_cfg = 1;
        model_reset();
        test_reset();
        test_sequential();
        test_align();
        test_predict();
        test_backpressure();
        test_redirect_wait();
        test_redirect_same();
        test_reset_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
